// File: rtl/thresh_window_ctrl_pkg.sv
// thresh_pkg: shared constants and FSM state type for the 3x3 window controller
package thresh_pkg;
    localparam int LINE_W_DEFAULT = 512;
    localparam int NUM_LINES      = 4;
    localparam int WIN_BYTES      = 9;
    typedef enum logic {IDLE, READ} state_t;
endpackage

// File: rtl/thresh_window_ctrl_line_buffer.sv
// line_buffer: one image line of register storage with a 3-pixel combinational read
module line_buffer
    import thresh_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [$clog2(LINE_W)-1:0] i_wr_ptr,
    input  logic [7:0]                i_data,
    input  logic [$clog2(LINE_W)-1:0] i_rd_ptr,
    output logic [23:0]               o_data
);
    localparam int AW = $clog2(LINE_W);
    logic [7:0]    r_mem [LINE_W];
    logic [AW-1:0] w_p1;
    logic [AW-1:0] w_p2;
    assign w_p1   = i_rd_ptr + AW'(1);
    assign w_p2   = i_rd_ptr + AW'(2);
    assign o_data = {r_mem[w_p2], r_mem[w_p1], r_mem[i_rd_ptr]};
    // storage write; contents are never reset, emptiness is tracked by the controller
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/thresh_window_ctrl.sv
// thresh_window_ctrl: 4-line ring buffer producing 3x3 pixel windows for thresholding
module thresh_window_ctrl
    import thresh_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEFAULT,
    parameter int CNT_W  = 14
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [7:0]             i_pixel_data,
    input  logic                   i_pixel_data_valid,
    output logic [8*WIN_BYTES-1:0] o_pixel_data,
    output logic                   o_pixel_data_valid,
    output logic                   o_intr,
    output logic                   o_overflow
);
    localparam int AW = $clog2(LINE_W);
    localparam int SW = $clog2(NUM_LINES);
    localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(NUM_LINES * LINE_W);
    localparam logic [CNT_W-1:0] C_START   = CNT_W'((NUM_LINES - 1) * LINE_W);
    localparam logic [CNT_W-1:0] C_LINE    = CNT_W'(LINE_W);
    localparam logic [AW-1:0]    C_WR_LAST = AW'(LINE_W - 1);
    localparam logic [AW-1:0]    C_RD_LAST = AW'(LINE_W - 3);

    state_t                 r_state;
    logic [AW-1:0]          r_wr_ptr;
    logic [SW-1:0]          r_wr_sel;
    logic [AW-1:0]          r_rd_ptr;
    logic [SW-1:0]          r_rd_sel;
    logic [CNT_W-1:0]       r_pix_cnt;
    logic [8*WIN_BYTES-1:0] r_data;
    logic                   r_valid;
    logic                   r_intr;
    logic                   r_overflow;
    logic                   w_accept;
    logic                   w_last;
    logic [SW-1:0]          w_sel1;
    logic [SW-1:0]          w_sel2;
    logic [23:0]            w_lb_data [NUM_LINES];
    logic [8*WIN_BYTES-1:0] w_window;

    assign w_accept = i_pixel_data_valid && (r_pix_cnt != C_FULL);
    assign w_last   = (r_state == READ) && (r_rd_ptr == C_RD_LAST);
    assign w_sel1   = r_rd_sel + SW'(1);
    assign w_sel2   = r_rd_sel + SW'(2);
    assign w_window = {w_lb_data[w_sel2], w_lb_data[w_sel1], w_lb_data[r_rd_sel]};

    assign o_pixel_data       = r_data;
    assign o_pixel_data_valid = r_valid;
    assign o_intr             = r_intr;
    assign o_overflow         = r_overflow;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_lb
        line_buffer #(.LINE_W(LINE_W)) u_lb (
            .i_clk    (i_clk),
            .i_we     (w_accept && (r_wr_sel == SW'(g))),
            .i_wr_ptr (r_wr_ptr),
            .i_data   (i_pixel_data),
            .i_rd_ptr (r_rd_ptr),
            .o_data   (w_lb_data[g])
        );
    end

    // write pointer walks the current line, then moves to the next buffer; full drops are sticky
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_wr_sel   <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_wr_ptr <= (r_wr_ptr == C_WR_LAST) ? '0 : r_wr_ptr + AW'(1);
            r_wr_sel <= (r_wr_ptr == C_WR_LAST) ? r_wr_sel + SW'(1) : r_wr_sel;
        end else if (i_pixel_data_valid) begin
            r_overflow <= 1'b1;
        end
    end

    // occupancy: +1 per stored pixel, -LINE_W when the reader releases a line, both may coincide
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_pix_cnt <= '0;
        else          r_pix_cnt <= r_pix_cnt + CNT_W'(w_accept) - (w_last ? C_LINE : '0);
    end

    // reader FSM: wait for three full lines, emit LINE_W-2 windows, release the oldest line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_rd_ptr <= '0;
            r_rd_sel <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_intr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_intr  <= 1'b0;
            if (r_state == IDLE) begin
                if (r_pix_cnt >= C_START) begin
                    r_state  <= READ;
                    r_rd_ptr <= '0;
                end
            end else begin
                r_data  <= w_window;
                r_valid <= 1'b1;
                if (w_last) begin
                    r_state  <= IDLE;
                    r_intr   <= 1'b1;
                    r_rd_sel <= r_rd_sel + SW'(1);
                end else begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end
endmodule

// File: doc/thresh_window_ctrl.md
THRESH_WINDOW_CTRL -- requirements
Module: thresh_window_ctrl

Interface
REQ-001 SHALL have parameter LINE_W, default 512: pixels per image line; legal range 4..4096.
REQ-002 SHALL have parameter CNT_W, default 14: width of the stored-pixel counter, sized to hold 4*LINE_W.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_pixel_data, input, 8: raster-order grayscale pixel.
REQ-006 SHALL have port i_pixel_data_valid, input, 1: i_pixel_data is valid this cycle; no backpressure.
REQ-007 SHALL have port o_pixel_data, output, 72: 3x3 window to the threshold datapath.
REQ-008 SHALL have port o_pixel_data_valid, output, 1: o_pixel_data is valid this cycle.
REQ-009 SHALL have port o_intr, output, 1: one-cycle pulse when a line has been consumed and its buffer is free for refill.
REQ-010 SHALL have port o_overflow, output, 1: sticky flag, pixel dropped because all buffers were full.

Function
REQ-011 SHALL hold 4 line buffers of LINE_W x 8 bits, used as a ring: one being written, three readable.
REQ-012 SHALL write each valid pixel to wr_sel at wr_ptr; wr_ptr increments; at LINE_W-1 it wraps to 0 and wr_sel advances modulo 4.
REQ-013 SHALL keep pix_cnt = pixels stored and not yet released; +1 per accepted pixel, -LINE_W per released line.
REQ-014 SHALL apply both updates in the same cycle on a simultaneous write and release: pix_cnt + 1 - LINE_W.
REQ-015 SHALL drop a valid pixel arriving when pix_cnt == 4*LINE_W; wr_ptr and pix_cnt unchanged; o_overflow set to 1 until reset.
REQ-016 SHALL implement an FSM with states IDLE and READ; reset state IDLE.
REQ-017 IDLE -> READ SHALL occur when pix_cnt >= 3*LINE_W; rd_ptr is cleared to 0 on entry.
REQ-018 In READ, the block SHALL issue one window read per cycle at columns rd_ptr, rd_ptr+1 and rd_ptr+2 of lines rd_sel, rd_sel+1 and rd_sel+2 (mod 4), then increment rd_ptr.
REQ-019 READ SHALL last exactly LINE_W-2 cycles, i.e. LINE_W-2 windows per line, with no edge padding.
REQ-020 READ -> IDLE SHALL occur after the window with rd_ptr == LINE_W-3; in that cycle o_intr pulses high, rd_sel advances modulo 4 and one line is released per REQ-013.
REQ-021 IDLE SHALL last at least one cycle between lines; consecutive lines therefore occupy LINE_W-1 cycles each.
REQ-022 Packing: byte i = o_pixel_data[i*8+:8], i = r*3+c; r=0 is the oldest line (rd_sel); c=0 is the leftmost column.
REQ-023 o_pixel_data and o_pixel_data_valid SHALL be registered; valid SHALL assert exactly 1 cycle after the read cycle.
REQ-024 o_pixel_data SHALL hold its last value while valid is low.
REQ-025 Writes into wr_sel SHALL proceed unchanged during READ; by construction, wr_sel never equals any line being read.

Reset
REQ-026 On i_rst_n low, the block SHALL asynchronously clear all of the following: state=IDLE, wr_ptr, wr_sel, rd_ptr, rd_sel, pix_cnt, o_pixel_data=0, o_pixel_data_valid=0, o_intr=0, o_overflow=0.
REQ-027 Reset mid-READ SHALL abort the line with no o_intr; buffer contents are not cleared and are treated as empty.
REQ-028 Reset deassertion SHALL be synchronised externally; the first accepted pixel is the first valid pixel after deassertion.

Structure
REQ-029 Shared package thresh_pkg SHALL hold: LINE_W default, NUM_LINES=4, WIN_BYTES=9, and the FSM state enum.
REQ-030 SHALL instantiate four line_buffer sub-modules, each with one write port and a combinational 3-pixel read at a given pointer (register-based; no reset of the storage).
REQ-031 Window mux and FSM SHALL reside in thresh_window_ctrl; implementation target 150-300 lines in total.

Verification (LINE_W=8)
REQ-032 Stimulus: 24 pixels of values 0..23, continuous. Required response: after the 24th pixel, 6 windows; first window bytes = {0,1,2,8,9,10,16,17,18}; o_intr pulses once at the end of the line.
REQ-033 Stimulus: continuous stream of 64 pixels. Required response: 6 lines read, 36 windows in total, 6 o_intr pulses, each line's windows contiguous, o_overflow stays 0.
REQ-034 Stimulus: 33 pixels, no reads possible (hold FSM via forced stall). Required response: 33rd pixel dropped, o_overflow=1, pix_cnt=32.
REQ-035 Stimulus: a pixel write in the same cycle as the last window of a line with pix_cnt=24. Required response: pix_cnt becomes 17.
REQ-036 Stimulus: i_rst_n pulsed low during the 3rd window of a line. Required response: outputs 0 immediately, no o_intr, FSM idle until 24 new pixels are stored.
REQ-037 Stimulus: pixel valid toggled randomly at a 50% rate. Required response: window contents match a reference model, and every window is preceded by pix_cnt >= 24.
